// File: rtl/prog_loader.sv
// Boot loader: accepts a length-prefixed byte stream of 16-bit words, writes them into
// instruction memory and releases the CPU from reset. Optional checksum trailer: LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_reset_n,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    HDR_HI  = 3'd0,
    HDR_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    CHK     = 3'd4,
`endif
    DONE    = 3'd5,
    ERROR   = 3'd6
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t END_STATE = CHK;
`else
  localparam state_t END_STATE = DONE;
`endif

  // One word per address; an image of exactly 2^ADDR_W words is still legal.
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  state_t              state_r;
  state_t              state_next_s;
  logic                in_ready_r;
  logic                mem_we_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [WORD_W-1:0]   mem_wdata_r;
  logic                cpu_reset_n_r;
  logic                load_done_r;
  logic                load_error_r;
  logic [ADDR_W:0]     word_count_r;
  logic [7:0]          count_hi_r;
  logic [15:0]         count_r;
  logic [7:0]          data_hi_r;
  logic                accept_s;
  logic [15:0]         hdr_count_s;
  logic                last_word_s;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          chk_acc_r;

  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  function automatic logic ready_in(input state_t s);
    return (s != DONE) && (s != ERROR);
  endfunction

  // Next-state decode; every transition is gated by an accepted byte.
  always_comb begin
    accept_s     = in_valid && in_ready_r;
    hdr_count_s  = {count_hi_r, in_data};
    last_word_s  = ({1'b0, count_r} == (17'(word_count_r) + 17'd1));
    state_next_s = state_r;
    case (state_r)
      HDR_HI: begin
        if (accept_s) state_next_s = HDR_LO;
        else          state_next_s = state_r;
      end
      HDR_LO: begin
        if (!accept_s)                               state_next_s = state_r;
        else if (hdr_count_s == 16'd0)               state_next_s = END_STATE;
        else if ({1'b0, hdr_count_s} > MAX_WORDS)    state_next_s = ERROR;
        else                                         state_next_s = DATA_HI;
      end
      DATA_HI: begin
        if (accept_s) state_next_s = DATA_LO;
        else          state_next_s = state_r;
      end
      DATA_LO: begin
        if (!accept_s)        state_next_s = state_r;
        else if (last_word_s) state_next_s = END_STATE;
        else                  state_next_s = DATA_HI;
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (!accept_s)                 state_next_s = state_r;
        else if (in_data == chk_acc_r) state_next_s = DONE;
        else                           state_next_s = ERROR;
      end
`endif
      DONE:    state_next_s = DONE;
      ERROR:   state_next_s = ERROR;
      default: state_next_s = ERROR;
    endcase
  end

  // State, datapath and registered status outputs; reset overrides a pending write.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r       <= HDR_HI;
      in_ready_r    <= 1'b1;
      mem_we_r      <= 1'b0;
      mem_addr_r    <= '0;
      mem_wdata_r   <= '0;
      cpu_reset_n_r <= 1'b0;
      load_done_r   <= 1'b0;
      load_error_r  <= 1'b0;
      word_count_r  <= '0;
      count_hi_r    <= 8'd0;
      count_r       <= 16'd0;
      data_hi_r     <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
      chk_acc_r     <= 8'd0;
`endif
    end else begin
      state_r       <= state_next_s;
      in_ready_r    <= ready_in(state_next_s);
      mem_we_r      <= accept_s && (state_r == DATA_LO);
      cpu_reset_n_r <= (state_next_s == DONE);
      load_done_r   <= (state_next_s == DONE);
      load_error_r  <= (state_next_s == ERROR);
      if (accept_s && (state_r == HDR_HI)) count_hi_r <= in_data;
      if (accept_s && (state_r == HDR_LO)) count_r <= hdr_count_s;
      if (accept_s && (state_r == DATA_HI)) data_hi_r <= in_data;
      if (accept_s && (state_r == DATA_LO)) begin
        mem_wdata_r  <= {data_hi_r, in_data};
        mem_addr_r   <= word_count_r[ADDR_W-1:0];
        word_count_r <= word_count_r + {{ADDR_W{1'b0}}, 1'b1};
      end
`ifdef LOADER_CHECKSUM_EN
      if (accept_s && ((state_r == DATA_HI) || (state_r == DATA_LO)))
        chk_acc_r <= chk_fold(chk_acc_r, in_data);
`endif
    end
  end

  assign in_ready    = in_ready_r;
  assign mem_we      = mem_we_r;
  assign mem_addr    = mem_addr_r;
  assign mem_wdata   = mem_wdata_r;
  assign cpu_reset_n = cpu_reset_n_r;
  assign load_done   = load_done_r;
  assign load_error  = load_error_r;
  assign word_count  = word_count_r;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: header/data streams, N=0, oversize header, gaps,
// mid-stream reset and a full 2^ADDR_W image; checksum cases when LOADER_CHECKSUM_EN is set.
module tb_prog_loader;
  localparam int ADDR_W = 8;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              cpu_reset_n;
  logic              load_done;
  logic              load_error;
  logic [ADDR_W:0]   word_count;

  int checks = 0;
  int passes = 0;
  int base;
  int errs;
  logic [ADDR_W-1:0] wa_q[$];
  logic [15:0]       wd_q[$];
  logic              wdone_q[$];
  logic [15:0]       img [0:511];

  always #5 clock = ~clock;

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset_n(cpu_reset_n), .load_done(load_done), .load_error(load_error),
    .word_count(word_count)
  );

  // Write monitor: records every memory write with load_done as seen in that cycle.
  always @(posedge clock) begin
    if (mem_we === 1'b1) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
      wdone_q.push_back(load_done);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b1;
  endtask

  function automatic int pick_gap(input int gmax);
    return (gmax == 0) ? 0 : int'($urandom_range(gmax, 0));
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int tries;
    repeat (gap) begin @(posedge clock); #1; end
    in_valid = 1'b1;
    in_data  = b;
    tries = 0;
    while (!in_ready && tries < 50) begin
      @(posedge clock); #1;
      tries++;
    end
    if (tries >= 50) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic drive_ignored(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_image(input int n, input int gap_max, input bit flip);
    logic [15:0] nn;
    logic [7:0]  chk;
    nn  = n[15:0];
    chk = 8'h00;
    send_byte(nn[15:8], pick_gap(gap_max));
    send_byte(nn[7:0], pick_gap(gap_max));
    for (int i = 0; i < n; i++) begin
      send_byte(img[i][15:8], pick_gap(gap_max));
      send_byte(img[i][7:0], pick_gap(gap_max));
      chk = chk ^ img[i][15:8] ^ img[i][7:0];
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(chk ^ {7'd0, flip}, pick_gap(gap_max));
`endif
  endtask

  task automatic check_two_word(input string tag);
    check({tag, "_nwrites"}, wa_q.size() - base, 32'd2);
    check({tag, "_addr0"}, {24'd0, wa_q[base]}, 32'h0);
    check({tag, "_data0"}, {16'd0, wd_q[base]}, 32'h1234);
    check({tag, "_done0"}, {31'd0, wdone_q[base]}, 32'd0);
    check({tag, "_addr1"}, {24'd0, wa_q[base+1]}, 32'h1);
    check({tag, "_data1"}, {16'd0, wd_q[base+1]}, 32'hABCD);
    check({tag, "_done1"}, {31'd0, wdone_q[base+1]}, {31'd0, !CHK_ON});
    check({tag, "_wcount"}, {23'd0, word_count}, 32'd2);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_done"}, {31'd0, load_done}, 32'd1);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) begin @(posedge clock); #1; end
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    check("rst_cpu_reset_n", {31'd0, cpu_reset_n}, 32'd0);
    check("rst_load_done", {31'd0, load_done}, 32'd0);
    check("rst_load_error", {31'd0, load_error}, 32'd0);
    check("rst_word_count", {23'd0, word_count}, 32'd0);
    reset = 1'b1;

    // Two-word image, back-to-back bytes
    base = wa_q.size();
    img[0] = 16'h1234; img[1] = 16'hABCD;
    send_image(2, 0, 1'b0);
    check("a_done_now", {31'd0, load_done}, 32'd1);
    check("a_cpu_rst_n", {31'd0, cpu_reset_n}, 32'd1);
    check("a_we_final", {31'd0, mem_we}, {31'd0, !CHK_ON});
    @(posedge clock); #1;
    check_two_word("a");
    check("a_we_after", {31'd0, mem_we}, 32'd0);
    repeat (3) drive_ignored(8'h5A);
    check("a_ignored_nwrites", wa_q.size() - base, 32'd2);
    check("a_ignored_done", {31'd0, load_done}, 32'd1);

    // Empty image
    do_reset();
    base = wa_q.size();
    send_image(0, 0, 1'b0);
    check("b_done", {31'd0, load_done}, 32'd1);
    check("b_cpu_rst_n", {31'd0, cpu_reset_n}, 32'd1);
    check("b_error", {31'd0, load_error}, 32'd0);
    @(posedge clock); #1;
    check("b_nwrites", wa_q.size() - base, 32'd0);
    check("b_in_ready", {31'd0, in_ready}, 32'd0);

    // Oversize header 0x0101 > 256 words
    do_reset();
    base = wa_q.size();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check("c_error", {31'd0, load_error}, 32'd1);
    check("c_cpu_rst_n", {31'd0, cpu_reset_n}, 32'd0);
    check("c_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 10; i++) drive_ignored(i[7:0]);
    check("c_error_held", {31'd0, load_error}, 32'd1);
    check("c_cpu_rst_n_held", {31'd0, cpu_reset_n}, 32'd0);
    check("c_done_low", {31'd0, load_done}, 32'd0);
    check("c_nwrites", wa_q.size() - base, 32'd0);

    // Same two-word image with random valid gaps
    do_reset();
    base = wa_q.size();
    img[0] = 16'h1234; img[1] = 16'hABCD;
    send_image(2, 5, 1'b0);
    @(posedge clock); #1;
    check_two_word("d");
    check("d_cpu_rst_n", {31'd0, cpu_reset_n}, 32'd1);

    // Reset after the first data byte, then a fresh one-word image
    do_reset();
    base = wa_q.size();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    do_reset();
    check("e_wcount_rst", {23'd0, word_count}, 32'd0);
    check("e_in_ready_rst", {31'd0, in_ready}, 32'd1);
    check("e_done_rst", {31'd0, load_done}, 32'd0);
    check("e_nwrites_rst", wa_q.size() - base, 32'd0);
    img[0] = 16'h5566;
    send_image(1, 0, 1'b0);
    @(posedge clock); #1;
    check("e_nwrites", wa_q.size() - base, 32'd1);
    check("e_addr0", {24'd0, wa_q[base]}, 32'h0);
    check("e_data0", {16'd0, wd_q[base]}, 32'h5566);
    check("e_done", {31'd0, load_done}, 32'd1);
    check("e_wcount", {23'd0, word_count}, 32'd1);

    // Full 256-word image: addresses reach 0xFF, count reaches 256
    do_reset();
    base = wa_q.size();
    for (int i = 0; i < 256; i++) img[i] = {i[7:0], ~i[7:0]};
    send_image(256, 0, 1'b0);
    @(posedge clock); #1;
    check("f_nwrites", wa_q.size() - base, 32'd256);
    errs = 0;
    for (int i = 0; i < 256 && (base + i) < wa_q.size(); i++) begin
      if (wa_q[base+i] !== i[7:0] || wd_q[base+i] !== {i[7:0], ~i[7:0]}) errs++;
    end
    check("f_seq_errors", errs, 32'd0);
    check("f_wcount", {23'd0, word_count}, 32'd256);
    check("f_last_addr", {24'd0, mem_addr}, 32'hFF);
    check("f_last_data", {16'd0, mem_wdata}, 32'hFF00);
    check("f_done", {31'd0, load_done}, 32'd1);
    check("f_error", {31'd0, load_error}, 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Checksum 0x12^0x34 = 0x26 accepted; 0x27 rejected after the word is written
    do_reset();
    base = wa_q.size();
    img[0] = 16'h1234;
    send_image(1, 0, 1'b0);
    check("g_done", {31'd0, load_done}, 32'd1);
    check("g_error", {31'd0, load_error}, 32'd0);
    check("g_nwrites", wa_q.size() - base, 32'd1);
    check("g_data0", {16'd0, wd_q[base]}, 32'h1234);
    do_reset();
    base = wa_q.size();
    send_image(1, 0, 1'b1);
    check("h_error", {31'd0, load_error}, 32'd1);
    check("h_done", {31'd0, load_done}, 32'd0);
    check("h_cpu_rst_n", {31'd0, cpu_reset_n}, 32'd0);
    check("h_nwrites", wa_q.size() - base, 32'd1);
    check("h_addr0", {24'd0, wa_q[base]}, 32'h0);
    check("h_data0", {16'd0, wd_q[base]}, 32'h1234);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
